// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: bus widths,
// hold codes, the NOP pattern and the prefetch FIFO entry layout.
package ifu_fetch_pkg;

    localparam int          INST_W      = 32;
    localparam int          INST_ADDR_W = 32;
    localparam int          HOLD_FLAG_W = 3;

    localparam logic [HOLD_FLAG_W-1:0] HOLD_NONE = 3'b000;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_PC   = 3'b001;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_IF   = 3'b010;
    localparam logic [HOLD_FLAG_W-1:0] HOLD_ID   = 3'b011;

    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0001;

    typedef logic [INST_W-1:0]      inst_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    typedef struct packed {
        inst_t      inst;
        inst_addr_t addr;
    } fifo_entry_t;

    function automatic inst_addr_t word_align(input inst_addr_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction bus with request/grant/rvalid handshake; the fetch unit is
// the master, the instruction memory is the slave.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic       req;
    inst_addr_t addr;
    logic       gnt;
    logic       rvalid;
    inst_t      rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/ifu_fifo.sv
// Two-entry prefetch FIFO holding {instruction, address} pairs, with a
// flush that takes priority over push and pop.
module ifu_fifo
    import ifu_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_i,
    input  fifo_entry_t entry_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic [1:0]  count_o,
    output fifo_entry_t head_o,
    output logic        empty_o
);

    fifo_entry_t mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: program counter, bus request issue, in-flight and
// stale-response tracking, and delivery from the prefetch FIFO to IF->ID.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_ADDR = 32'h0000_0000
)(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
    input  logic                   jump_flag_i,
    input  inst_addr_t             jump_addr_i,
    ifu_fetch_if.master            ibus,
    output logic                   inst_valid_o,
    output inst_t                  inst_o,
    output inst_addr_t             inst_addr_o
);

    localparam inst_addr_t RESET_PC = {RESET_ADDR[31:2], 2'b00};

    inst_addr_t pc_q, pc_d;
    inst_addr_t resp_addr_q, resp_addr_d;
    logic [2:0] os_q, os_d;
    logic [2:0] dc_q, dc_d;

    logic [1:0]  fifo_count;
    fifo_entry_t fifo_head;
    fifo_entry_t fifo_entry;
    logic        fifo_empty;

    logic       hold_en, deliver, pop, req, grant, rsp, discard, push;
    logic [2:0] live, committed;
    inst_addr_t jump_target;

    assign hold_en     = (hold_flag_i >= HOLD_IF);
    assign deliver     = !fifo_empty && !jump_flag_i;
    assign pop         = deliver && !hold_en;
    assign jump_target = word_align(jump_addr_i);

    // Stale in-flight words never occupy a FIFO slot, and the slot freed by
    // this cycle's pop is reusable, which sustains one fetch per cycle.
    assign live      = os_q - dc_q;
    assign committed = {1'b0, fifo_count} - {2'b00, pop} + live;
    assign req       = rstn && !jump_flag_i && (committed < 3'd2);

    assign grant      = req && ibus.gnt;
    assign rsp        = ibus.rvalid;
    assign discard    = rsp && (dc_q != 3'd0);
    assign push       = rsp && !discard && !jump_flag_i;
    assign fifo_entry = '{inst: ibus.rdata, addr: resp_addr_q};

    always_comb begin
        pc_d        = pc_q;
        resp_addr_d = resp_addr_q;
        os_d        = os_q + {2'b00, grant} - {2'b00, rsp};
        dc_d        = dc_q;
        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        if (discard) begin
            dc_d = dc_q - 3'd1;
        end else if (rsp) begin
            resp_addr_d = resp_addr_q + 32'd4;
        end
        // Every word still outstanding after a jump belongs to the old path.
        if (jump_flag_i) begin
            pc_d        = jump_target;
            resp_addr_d = jump_target;
            dc_d        = os_q + {2'b00, grant} - {2'b00, rsp};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= RESET_PC;
            resp_addr_q <= RESET_PC;
            os_q        <= 3'd0;
            dc_q        <= 3'd0;
        end else begin
            pc_q        <= pc_d;
            resp_addr_q <= resp_addr_d;
            os_q        <= os_d;
            dc_q        <= dc_d;
        end
    end

    ifu_fifo u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .entry_i (fifo_entry),
        .pop_i   (pop),
        .flush_i (jump_flag_i),
        .count_o (fifo_count),
        .head_o  (fifo_head),
        .empty_o (fifo_empty)
    );

    assign ibus.req     = req;
    assign ibus.addr    = pc_q;
    assign inst_valid_o = deliver;
    assign inst_o       = deliver ? fifo_head.inst : INST_NOP;
    assign inst_addr_o  = deliver ? fifo_head.addr : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a cycle table for streaming, hold and jump,
// plus sequences for stale drops, grant stalls, varied latency and reset.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    typedef struct {
        logic [2:0]  hold;
        logic        jump;
        logic [31:0] jaddr;
        logic        gnt;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstAddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  holdFlag = 3'b000;
    logic        jumpFlag = 1'b0;
    logic [31:0] jumpAddr = 32'h0;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instAddr;

    int   testsRun = 0;
    int   testsFailed = 0;
    int   cyc = 0;
    int   lat = 1;
    rsp_t pend[$];
    vec_t vecs [18];

    ifu_fetch_if ibus();

    ifu_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .hold_flag_i  (holdFlag),
        .jump_flag_i  (jumpFlag),
        .jump_addr_i  (jumpAddr),
        .ibus         (ibus),
        .inst_valid_o (instValid),
        .inst_o       (inst),
        .inst_addr_o  (instAddr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One clock cycle: drive inputs and the memory response after the edge,
    // then at the falling edge log any grant for the memory model.
    task automatic applyStimulus(input logic [2:0] hold, input logic jump, input logic [31:0] jaddr, input logic gnt);
        int due;
        @(posedge clk);
        #1;
        cyc++;
        holdFlag = hold;
        jumpFlag = jump;
        jumpAddr = jaddr;
        ibus.gnt = gnt;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ibus.rvalid = 1'b1;
            ibus.rdata  = memData(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            ibus.rvalid = 1'b0;
            ibus.rdata  = 32'h0;
        end
        @(negedge clk);
        if (ibus.req && ibus.gnt) begin
            due = cyc + lat;
            if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
            pend.push_back('{addr: ibus.addr, due: due});
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req"}, {31'b0, ibus.req}, 32'd0);
        checkOutput({tag, " addr"}, ibus.addr, 32'h0);
        checkOutput({tag, " valid"}, {31'b0, instValid}, 32'd0);
        checkOutput({tag, " inst"}, inst, INST_NOP);
        checkOutput({tag, " instAddr"}, instAddr, 32'h0);
    endtask

    task automatic doReset();
        rstn        = 1'b0;
        holdFlag    = HOLD_NONE;
        jumpFlag    = 1'b0;
        jumpAddr    = 32'h0;
        ibus.gnt    = 1'b0;
        ibus.rvalid = 1'b0;
        ibus.rdata  = 32'h0;
        pend.delete();
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        checkOutput("release req", {31'b0, ibus.req}, 32'd1);
        cyc = -1;
    endtask

    initial begin
        int expNext;
        int delivered;
        logic h;

        vecs[0]  = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h0};
        vecs[1]  = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h0};
        vecs[2]  = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h08,  1'b1, 32'h00};
        vecs[3]  = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0C,  1'b1, 32'h04};
        vecs[4]  = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h08};
        vecs[5]  = '{HOLD_IF,   1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h0C};
        vecs[6]  = '{HOLD_IF,   1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h0C};
        vecs[7]  = '{HOLD_IF,   1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h0C};
        vecs[8]  = '{HOLD_IF,   1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h0C};
        vecs[9]  = '{HOLD_IF,   1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  1'b1, 32'h0C};
        vecs[10] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h0C};
        vecs[11] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'h10};
        vecs[12] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h14};
        vecs[13] = '{HOLD_NONE, 1'b1, 32'h106, 1'b1, 1'b0, 32'h20,  1'b0, 32'h0};
        vecs[14] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        vecs[15] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b0, 32'h0};
        vecs[16] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        vecs[17] = '{HOLD_NONE, 1'b0, 32'h0,   1'b1, 1'b1, 32'h110, 1'b1, 32'h108};

        // Streaming, hold fill/release and a jump coinciding with rvalid.
        doReset();
        lat = 1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].hold, vecs[i].jump, vecs[i].jaddr, vecs[i].gnt);
            checkOutput($sformatf("vec%0d req", i), {31'b0, ibus.req}, {31'b0, vecs[i].eReq});
            checkOutput($sformatf("vec%0d addr", i), ibus.addr, vecs[i].eAddr);
            checkOutput($sformatf("vec%0d valid", i), {31'b0, instValid}, {31'b0, vecs[i].eValid});
            checkOutput($sformatf("vec%0d instAddr", i), instAddr, vecs[i].eInstAddr);
            checkOutput($sformatf("vec%0d inst", i), inst,
                        vecs[i].eValid ? memData(vecs[i].eInstAddr) : INST_NOP);
        end

        // Jump with two fetches in flight at three-cycle latency.
        doReset();
        lat = 3;
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c0 addr", ibus.addr, 32'h0);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c1 addr", ibus.addr, 32'h4);
        applyStimulus(HOLD_NONE, 1'b1, 32'h0000_0106, 1'b1);
        checkOutput("seqA jump req", {31'b0, ibus.req}, 32'd0);
        checkOutput("seqA jump valid", {31'b0, instValid}, 32'd0);
        checkOutput("seqA jump inst", inst, INST_NOP);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c3 req", {31'b0, ibus.req}, 32'd1);
        checkOutput("seqA c3 addr", ibus.addr, 32'h104);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c4 addr", ibus.addr, 32'h108);
        checkOutput("seqA c4 valid", {31'b0, instValid}, 32'd0);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c5 req", {31'b0, ibus.req}, 32'd0);
        checkOutput("seqA c5 valid", {31'b0, instValid}, 32'd0);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c6 valid", {31'b0, instValid}, 32'd0);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c7 valid", {31'b0, instValid}, 32'd1);
        checkOutput("seqA c7 instAddr", instAddr, 32'h104);
        checkOutput("seqA c7 inst", inst, memData(32'h104));
        checkOutput("seqA c7 addr", ibus.addr, 32'h10C);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("seqA c8 instAddr", instAddr, 32'h108);

        // Grant stalled three cycles, then varied latency with periodic hold.
        doReset();
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("stall%0d req", i), {31'b0, ibus.req}, 32'd1);
            checkOutput($sformatf("stall%0d addr", i), ibus.addr, 32'h0);
        end
        expNext = 0;
        delivered = 0;
        for (int k = 0; k < 40; k++) begin
            lat = 1 + (k % 3);
            h = (k % 5 == 4);
            applyStimulus(h ? HOLD_IF : HOLD_NONE, 1'b0, 32'h0, 1'b1);
            if (instValid) begin
                checkOutput($sformatf("seqB k%0d instAddr", k), instAddr, expNext);
                checkOutput($sformatf("seqB k%0d inst", k), inst, memData(expNext));
                if (!h) begin
                    expNext += 4;
                    delivered++;
                end
            end
        end
        checkOutput("seqB progress", {31'b0, delivered > 10}, 32'd1);

        // Asynchronous reset in the middle of the stream, then restart.
        rstn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        doReset();
        lat = 1;
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("restart c0 addr", ibus.addr, 32'h0);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("restart c1 addr", ibus.addr, 32'h4);
        applyStimulus(HOLD_NONE, 1'b0, 32'h0, 1'b1);
        checkOutput("restart c2 valid", {31'b0, instValid}, 32'd1);
        checkOutput("restart c2 instAddr", instAddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
